queue_calc_sequencer: RTL
=========================

# queue_calc_sequencer

Command-level controller for the 5-entry, 8-bit `queue_with_controller` operand queue. It accepts calculator commands over a valid/ready channel and checks occupancy against a shadow count, so the queue's sticky `is_err` is never triggered by legal traffic. It drives the queue's one-cycle opcodes, computes ALU results from the queue's front pair, and returns one response per command over a second valid/ready channel. It sits between the command source (host/decoder) and the queue instance.

## Interface
- `DEPTH`, 5: queue capacity; must equal queue array size.
- `W`, 8: data width; must equal queue entry width.

- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_op`  in  3  command code.
- `cmd_data`  in  W  push operand.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  W  result value.
- `rsp_err`  out  2  0 ok, 1 overflow, 2 underflow, 3 fault.
- `q_opcode`  out  2  to queue: 00 push, 01 idle, 10 combine, 11 pop.
- `q_back`  out  W  to queue `back`.
- `q_top_conc`  in  2W  from queue; `[W-1:0]` is front, `[2W-1:W]` is second.
- `q_is_empty`  in  1  from queue.
- `q_is_err`  in  1  from queue.
- `count`  out  3  shadow occupancy, 0..DEPTH.
- `fault`  out  1  sticky queue fault.

## Operation
- `cmd_op` codes:
  - 000 PUSH
  - 001 ADD
  - 010 SUB (front − second)
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 POP
  - 111 CLEAR
- ALU results are modulo 2^W; carry and borrow are discarded.
- FSM states: IDLE, ISSUE, CLEAR, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On handshake, latch op and data, then go to ISSUE.
  - If `fault`=1, go to RESP with err=3 instead.
- ISSUE (one cycle):
  - Legality check against `count`:
    - PUSH with `count`==DEPTH → err 1.
    - ALU op with `count`<2 → err 2.
    - POP with `count`==0 → err 2.
  - Illegal command: `q_opcode`=01 and the queue is untouched.
  - PUSH: `q_opcode`=00, `q_back`=data, `rsp_data`=data, `count`+1.
  - ALU op: `q_opcode`=10, `q_back`=alu(front, second), `rsp_data`=that result, `count`−1.
  - POP: `q_opcode`=11, `rsp_data`=front, `count`−1.
  - CLEAR: go to CLEAR state with the removed-entry counter at 0.
  - All other ops go to RESP.
- CLEAR:
  - While `count`>0, drive `q_opcode`=11 each cycle, decrement `count`, and increment the removed-entry counter.
  - When `count`==0, go to RESP with `rsp_data`=removed count.
  - CLEAR on an empty queue gives `rsp_data`=0, err 0.
- RESP:
  - `rsp_valid`=1; `rsp_data` and `rsp_err` stay stable until `rsp_ready`.
  - On handshake, return to IDLE.
- `q_opcode`=01 and `q_back`=0 in every state and cycle not listed above.
- Fault:
  - `fault` is set if `q_is_err`=1 in any cycle.
  - `fault` is also set if, in IDLE, `q_is_empty` disagrees with (`count`==0).
  - Once set, `fault` clears only on `rst`; every later command gets err 3 and no queue op.
- Any error response leaves `count` unchanged.

## Timing
- Reset values:
  - state IDLE, `count`=0, `fault`=0.
  - `cmd_ready`=1 once `rst` is released; `rsp_valid`=0.
  - `rsp_data`=0, `rsp_err`=0.
  - `q_opcode`=01, `q_back`=0.
- Latency, non-CLEAR command accepted at edge N:
  - ISSUE during cycle N..N+1; the queue updates at edge N+1.
  - `rsp_valid` is high from edge N+1.
  - Earliest next accept is the edge after the response handshake, so throughput is 1 command per 3 cycles at full rate.
- CLEAR with k entries: k pop cycles after ISSUE, then RESP.
- `rsp_ready` held low: the FSM stays in RESP and `cmd_ready`=0, giving backpressure.
- Reset mid-operation:
  - Everything returns to its reset value asynchronously.
  - The queue shares `rst`, so both sides are empty and consistent.
  - A pending response is dropped.
- `count` updates on the same edge the queue commits its opcode.

## Structure
- Shared package `queue_calc_pkg`:
  - `cmd_op` localparams.
  - Queue opcode constants (PUSH/IDLE/COMBINE/POP).
  - `rsp_err` codes.
  - FSM state encoding.
  - `DEPTH`/`W` defaults.
- Sub-module `queue_calc_alu`: combinational; (op, a=front, b=second) → W-bit result.
- Top level holds the FSM, shadow count, removed-entry counter, response registers and fault logic.

## Test plan
- Push 0x10, 0x20, then ADD.
  - Responses: 0x10 ok, 0x20 ok, 0x30 ok.
  - `count` ends at 1; queue front = 0x30.
- Push 5 values, then a 6th PUSH (0x77).
  - 6th response err 1.
  - `count`=5; `q_opcode` is never 00 for the 6th; `fault`=0.
- From empty: push 0x05, then SUB.
  - SUB response err 2; `count`=1.
- Push 0x03, 0xFF, then SUB.
  - Response 0x04 (0x03−0xFF mod 256).
  - Then POP → 0x04; then POP → err 2.
- Push 3 values, then CLEAR with `rsp_ready` low for 4 cycles.
  - Exactly 3 pop cycles.
  - `rsp_data`=3 held stable through the stall; `cmd_ready`=0 until the response handshake.
- Force `q_is_err`=1 for one cycle, then PUSH 0x01.
  - Response err 3; `fault` stays 1.
  - Assert `rst` mid-CLEAR: all outputs return to reset values immediately.

Source files
------------

// File: rtl/queue_calc_sequencer_pkg.sv
// queue_calc_pkg: shared constants for the queue calculator sequencer.
// Holds command codes, queue opcodes, response error codes, FSM state
// encoding and default DEPTH/W.
package queue_calc_pkg;

  localparam int unsigned DEPTH_DEF = 5;
  localparam int unsigned W_DEF     = 8;

  // Command codes on cmd_op
  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_POP   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  // Queue opcodes on q_opcode
  localparam logic [1:0] QOP_PUSH    = 2'b00;
  localparam logic [1:0] QOP_IDLE    = 2'b01;
  localparam logic [1:0] QOP_COMBINE = 2'b10;
  localparam logic [1:0] QOP_POP     = 2'b11;

  // Response error codes on rsp_err
  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_OVF   = 2'd1;
  localparam logic [1:0] ERR_UNF   = 2'd2;
  localparam logic [1:0] ERR_FAULT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CLEAR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/queue_calc_sequencer_if.sv
// queue_calc_sequencer_if: command and response valid/ready channels.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command channel (host -> sequencer)
//   rsp_valid/rsp_ready/rsp_data/rsp_err : response channel (sequencer -> host)
// master = command source / response sink, slave = sequencer.
interface queue_calc_sequencer_if #(
  parameter int unsigned W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/queue_calc_sequencer_alu.sv
// queue_calc_alu: combinational ALU over the queue front pair.
//   op : command code (ALU codes only; others give 0)
//   a  : queue front
//   b  : queue second entry
//   y  : W-bit result, modulo 2^W
module queue_calc_alu
  import queue_calc_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/queue_calc_sequencer.sv
// queue_calc_sequencer: command-level controller for a DEPTH-entry queue.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : command/response channels (slave modport)
//   q_opcode   : queue opcode (00 push, 01 idle, 10 combine, 11 pop)
//   q_back     : value written to the queue back
//   q_top_conc : {second, front} from the queue
//   q_is_empty : queue empty flag
//   q_is_err   : queue sticky error flag
//   count      : shadow occupancy
//   fault      : sticky fault (queue error or occupancy disagreement)
module queue_calc_sequencer
  import queue_calc_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  queue_calc_sequencer_if.slave bus,
  output logic [1:0]           q_opcode,
  output logic [W-1:0]         q_back,
  input  logic [2*W-1:0]       q_top_conc,
  input  logic                 q_is_empty,
  input  logic                 q_is_err,
  output logic [2:0]           count,
  output logic                 fault
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  state_e       state_q;
  logic [2:0]   op_q;
  logic [2:0]   count_q;
  logic [2:0]   removed_q;
  logic         fault_q;
  logic         cmd_ready_q;
  logic         rsp_valid_q;
  logic [W-1:0] rsp_data_q;
  logic [1:0]   rsp_err_q;
  logic [1:0]   q_opcode_q;
  logic [W-1:0] q_back_q;

  logic [W-1:0] front;
  logic [W-1:0] second;
  logic [W-1:0] alu_y;

  logic [1:0]   iss_err;
  logic [1:0]   iss_qop;
  logic [W-1:0] iss_back;
  logic [W-1:0] iss_data;
  logic [2:0]   count_d;
  logic         fault_d;

  assign front  = q_top_conc[W-1:0];
  assign second = q_top_conc[2*W-1:W];

  queue_calc_alu #(.W(W)) u_alu (
    .op (bus.cmd_op),
    .a  (front),
    .b  (second),
    .y  (alu_y)
  );

  // The ISSUE-cycle opcode is registered, so the legality check and ALU
  // evaluation happen on the accepted command; the queue is idle in IDLE,
  // so front/second are the same values the ISSUE cycle would see.
  always_comb begin
    iss_err  = ERR_OK;
    iss_qop  = QOP_IDLE;
    iss_back = '0;
    iss_data = '0;
    case (bus.cmd_op)
      OP_PUSH: begin
        if (count_q == DEPTH_C) begin
          iss_err = ERR_OVF;
        end else begin
          iss_qop  = QOP_PUSH;
          iss_back = bus.cmd_data;
          iss_data = bus.cmd_data;
        end
      end
      OP_POP: begin
        if (count_q == 3'd0) begin
          iss_err = ERR_UNF;
        end else begin
          iss_qop  = QOP_POP;
          iss_data = front;
        end
      end
      OP_CLEAR: ;
      default: begin
        if (count_q < 3'd2) begin
          iss_err = ERR_UNF;
        end else begin
          iss_qop  = QOP_COMBINE;
          iss_back = alu_y;
          iss_data = alu_y;
        end
      end
    endcase
  end

  // Shadow count follows the opcode the queue commits this cycle.
  always_comb begin
    count_d = count_q;
    case (q_opcode_q)
      QOP_PUSH:             count_d = count_q + 3'd1;
      QOP_COMBINE, QOP_POP: count_d = count_q - 3'd1;
      default:              count_d = count_q;
    endcase
  end

  always_comb begin
    fault_d = fault_q | q_is_err;
    if (state_q == ST_IDLE && (q_is_empty != (count_q == 3'd0))) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH;
      count_q     <= '0;
      removed_q   <= '0;
      fault_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_OK;
      q_opcode_q  <= QOP_IDLE;
      q_back_q    <= '0;
    end else begin
      fault_q <= fault_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            op_q        <= bus.cmd_op;
            if (fault_q) begin
              rsp_err_q   <= ERR_FAULT;
              rsp_data_q  <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              rsp_err_q  <= iss_err;
              rsp_data_q <= iss_data;
              q_opcode_q <= iss_qop;
              q_back_q   <= iss_back;
              state_q    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          count_q    <= count_d;
          q_opcode_q <= QOP_IDLE;
          q_back_q   <= '0;
          if (op_q == OP_CLEAR) begin
            removed_q <= '0;
            if (count_q != 3'd0) begin
              q_opcode_q <= QOP_POP;
            end
            state_q <= ST_CLEAR;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_CLEAR: begin
          // A pop is on the queue exactly when count_q is nonzero here.
          if (count_q != 3'd0) begin
            count_q   <= count_q - 3'd1;
            removed_q <= removed_q + 3'd1;
            if (count_q == 3'd1) begin
              q_opcode_q  <= QOP_IDLE;
              rsp_data_q  <= W'(removed_q + 3'd1);
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end else begin
            rsp_data_q  <= W'(removed_q);
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign q_opcode      = q_opcode_q;
  assign q_back        = q_back_q;
  assign count         = count_q;
  assign fault         = fault_q;

endmodule
